// File: rtl/icache_line_fill.sv
// Direct-mapped read-only instruction cache with a single outstanding 128-bit
// line fill; hits are served combinationally, misses stall the fetch stage.
module icache_line_fill #(
    parameter int SETS = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic [31:0]  address,
    output logic [31:0]  instruction,
    output logic         busywait,
    input  logic         flush,
    output logic         mem_read,
    output logic [27:0]  mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        FILL
    } state_t;

    state_t state, state_next;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [127:0]     data_mem [SETS];
    logic [27:0]      miss_addr;
    logic             flush_pending;

    logic [TAG_W-1:0] addr_tag;
    logic [IDX_W-1:0] addr_idx;
    logic [1:0]       addr_off;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic [127:0]     line_data;
    logic             hit;
    logic             miss;
    logic             unused_addr_bits;

    assign addr_tag  = address[31:4+IDX_W];
    assign addr_idx  = address[4+IDX_W-1:4];
    assign addr_off  = address[3:2];
    assign fill_idx  = miss_addr[IDX_W-1:0];
    assign fill_tag  = miss_addr[27:IDX_W];
    assign line_data = data_mem[addr_idx];

    // Instruction fetches are word aligned; the byte offset carries no information.
    assign unused_addr_bits = ^address[1:0];

    assign hit  = reset && read && (state == IDLE) && valid[addr_idx]
                  && (tag_mem[addr_idx] == addr_tag);
    assign miss = reset && read && (state == IDLE) && !hit;

    assign busywait    = reset && read && !hit;
    assign instruction = hit ? line_data[{addr_off, 5'b0} +: 32] : 32'h0;
    assign mem_address = miss_addr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        unique case (state)
            IDLE: begin
                if (miss) begin
                    state_next = MEM_READ;
                end
            end
            MEM_READ: begin
                mem_read = reset;
                if (!mem_busywait) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A flush seen mid-fill is deferred so the fill finishes, then wipes every line.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid         <= '0;
            flush_pending <= 1'b0;
            miss_addr     <= '0;
        end else begin
            if (miss) begin
                miss_addr <= address[31:4];
            end
            if (state == FILL) begin
                valid[fill_idx] <= 1'b1;
            end
            if ((state == IDLE) && (flush || flush_pending)) begin
                valid <= '0;
            end
            if (state == IDLE) begin
                flush_pending <= 1'b0;
            end else begin
                flush_pending <= flush_pending | flush;
            end
        end
    end

    // The last beat of the block is already on mem_readdata while in FILL.
    always_ff @(posedge clock) begin
        if (reset && (state == FILL)) begin
            data_mem[fill_idx] <= mem_readdata;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

endmodule

// File: doc/icache_line_fill.md
# icache_line_fill

Direct-mapped instruction cache between the CPU fetch stage and the 128-bit block instruction memory. Hits return a 32-bit instruction in the same cycle. Misses stall the CPU through `busywait` and run a block-read handshake with the memory. The memory takes 16 cycles per 128-bit block, and the cache writes the returned block into the indexed line.

## Interface
- `SETS`, 8: number of lines, power of two; index width is log2(SETS) = 3.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset; sampled on the rising edge of `clock`.
- `read` in 1: CPU fetch request; held high until `busywait` is low.
- `address` in 32: byte PC; bits [1:0] are ignored.
- `instruction` out 32: fetched word; valid when `read` is high and `busywait` is low.
- `busywait` out 1: CPU stall.
- `flush` in 1: single-cycle pulse that invalidates all lines.
- `mem_read` out 1: block read request to the memory.
- `mem_address` out 28: block address, equal to `address[31:4]`.
- `mem_readdata` in 128: block data; byte k is in bits [8k+7:8k].
- `mem_busywait` in 1: memory busy; goes low in the last transfer cycle.

## Operation
- Address split: tag = `address[31:7]` (25 bits), index = `address[6:4]`, word offset = `address[3:2]`.
- Storage per line:
  - valid bit;
  - 25-bit tag;
  - 128-bit data.
- Hit (combinational): `read` is high, state is IDLE, the line is valid and the stored tag equals the address tag.
- Word select on hit: `instruction` = data[32*offset+31 : 32*offset]. The word is little-endian, so the byte at address n is the low byte.
- When there is no hit, `instruction` is 32'h0.
- `busywait` = `read` AND NOT hit. It is forced to 0 while `reset` is low.
- FSM states: IDLE, MEM_READ, FILL.
  - IDLE: stays here on a hit or when `read` is low. On a miss it goes to MEM_READ and latches `address[31:4]` into the miss-address register.
  - MEM_READ: `mem_read` = 1 and `mem_address` = the latched block address. When `mem_busywait` is sampled low, go to FILL; otherwise stay.
  - FILL: `mem_read` = 0. The final byte lands in `mem_readdata` at this cycle's entry edge, so the line is captured here. On the FILL→IDLE edge, write `mem_readdata`, the latched tag and valid=1 into the latched index, then go to IDLE.
- `mem_read` drops in the cycle after the last transfer. This keeps the memory's transfer counter at 0 for the next request.
- Outside MEM_READ, `mem_address` still shows the latched block address and `mem_read` is 0.
- Flush:
  - In IDLE, clear every valid bit on the next edge. A hit in that same cycle is still served.
  - In MEM_READ or FILL, set `flush_pending`. The fill completes normally, then all valid bits (including the new line) are cleared on the first IDLE edge.
- Address change during a miss: `address` may change while `busywait` is high. The fill uses only the latched address, and hit/miss is re-evaluated in IDLE.

## Timing
- Reset (`reset` low at an edge):
  - state = IDLE;
  - all valid bits = 0;
  - `flush_pending` = 0;
  - miss-address register = 0.
- Output values while `reset` is low: `mem_read` = 0, `busywait` = 0, `instruction` = 0.
- Reset mid-fill: the transfer is abandoned and no line is written. The memory is reset from the same system reset.
- Hit latency: 0 cycles, with `instruction` and `busywait` = 0 in the same cycle.
- Miss latency, with cycle 0 as the IDLE miss cycle:
  - cycles 1–16: MEM_READ, with `mem_busywait` low in cycle 16;
  - cycle 17: FILL;
  - cycle 18: IDLE hit, `busywait` = 0.
- `busywait` is high for exactly 18 cycles.
- Back-to-back misses to different sets: each costs 18 cycles, with no overlap.
- A miss that evicts a valid line replaces it with no write-back, since the cache is read-only.

## Test plan
- Reset then cold fetch: `reset` low for 2 cycles, then `read`=1, `address`=0x00 → `mem_read` high for cycles 1–16 with `mem_address`=0, `busywait` high for 18 cycles, then `instruction`=0xc1800013.
- Same-block hits: after the above, `address`=0x04 then 0x0C → `busywait`=0 immediately, `instruction`=0x00208093 then 0x00000000, `mem_read` stays 0.
- Second block: `address`=0x18 → 18-cycle miss with `mem_address`=1, then `instruction`=0x0000207f. `address`=0x1C then hits with 0x0000a2a3.
- Conflict eviction: fill address 0x00, then fetch 0x80 (same index 0, tag 1) → miss and refill. Refetch 0x00 → miss again (18 cycles).
- Flush:
  - Pulse `flush` in IDLE after filling block 0, then fetch 0x00 → miss.
  - Pulse `flush` during MEM_READ → that fill completes, then the next fetch of the same address misses.
- Reset mid-fill: drop `reset` in MEM_READ cycle 8 → `mem_read`=0 at the next edge, state is IDLE, and a later fetch of 0x00 performs a full 18-cycle miss returning 0xc1800013.
